// File: rtl/fpu_pkg.sv
// Shared types, unit indices, flag positions and IEEE-layout helpers for the FPU dispatch controller.
package fpu_pkg;

   typedef enum logic [1:0] {
      FN_ADD = 2'd0,
      FN_SUB = 2'd1,
      FN_DIV = 2'd2,
      FN_MUL = 2'd3
   } funct_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HOLD
   } state_e;

   localparam logic [1:0] U_ADD = 2'd0;
   localparam logic [1:0] U_DIV = 2'd1;
   localparam logic [1:0] U_MUL = 2'd2;

   localparam int unsigned FLG_ZERO    = 0;
   localparam int unsigned FLG_OVF     = 1;
   localparam int unsigned FLG_UND     = 2;
   localparam int unsigned FLG_TIMEOUT = 3;
   localparam int unsigned FLG_INVALID = 4;

   // Helpers work on a zero-extended container so one definition serves any EXP_W/MAN_W.
   localparam int unsigned FP_MAX_W = 64;

   function automatic logic [1:0] unit_of(input funct_e f);
      case (f)
         FN_DIV:  return U_DIV;
         FN_MUL:  return U_MUL;
         default: return U_ADD;
      endcase
   endfunction

   function automatic logic is_nan(input logic [FP_MAX_W-1:0] x,
                                   input int unsigned exp_w,
                                   input int unsigned man_w);
      logic exp_ones;
      logic man_nz;
      exp_ones = 1'b1;
      man_nz   = 1'b0;
      for (int unsigned i = 0; i < FP_MAX_W; i++) begin
         if (i < man_w)
            man_nz = man_nz | x[i];
         else if (i < man_w + exp_w)
            exp_ones = exp_ones & x[i];
      end
      return exp_ones & man_nz;
   endfunction

   function automatic logic [FP_MAX_W-1:0] qnan(input int unsigned exp_w,
                                                input int unsigned man_w);
      logic [FP_MAX_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < FP_MAX_W; i++)
         r[i] = (i == man_w - 1) || ((i >= man_w) && (i < man_w + exp_w));
      return r;
   endfunction

endpackage

// File: rtl/fpu_watchdog.sv
// Wait-phase cycle counter; expired flags the last permitted wait cycle (count == TIMEOUT-1).
module fpu_watchdog #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + CNT_W'(1);
   end

   assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_dispatch_ctrl.sv
// FPU front-end: accepts one op, starts exactly one arithmetic unit, waits under a watchdog,
// and holds result/flags/tag until the consumer takes them.
module fpu_dispatch_ctrl
   import fpu_pkg::*;
#(
   parameter int unsigned EXP_W   = 8,
   parameter int unsigned MAN_W   = 23,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned TIMEOUT = 64,
   localparam int unsigned WIDTH  = 1 + EXP_W + MAN_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_funct,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_result,
   output logic [4:0]         out_flags,
   output logic [TAG_W-1:0]   out_tag,
   output logic [2:0]         unit_start,
   output logic               unit_sub,
   output logic [WIDTH-1:0]   unit_a,
   output logic [WIDTH-1:0]   unit_b,
   input  logic [3*WIDTH-1:0] unit_res,
   input  logic [2:0]         unit_done,
   input  logic [8:0]         unit_flags
);

   localparam logic [FP_MAX_W-1:0] QNAN_FULL = qnan(EXP_W, MAN_W);
   localparam logic [WIDTH-1:0]    QNAN      = QNAN_FULL[WIDTH-1:0];

   state_e             state_q, state_d;
   logic [1:0]         sel_q;
   logic               op_nan_q;
   logic [TAG_W-1:0]   tag_q;
   logic               accept;
   logic               done_sel;
   logic [WIDTH-1:0]   sel_res;
   logic [2:0]         sel_flags;
   logic [4:0]         unit_flags_n;
   logic               wd_expired;
   logic [FP_MAX_W-1:0] a_ext, b_ext;

   assign accept    = (state_q == S_IDLE) && in_valid;
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_HOLD);
   assign a_ext     = FP_MAX_W'(in_a);
   assign b_ext     = FP_MAX_W'(in_b);

   fpu_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state_q == S_ISSUE),
      .enable (state_q == S_WAIT),
      .expired(wd_expired)
   );

   // Only the selected unit's done/result/flags are visible; the other units are ignored.
   always_comb begin
      done_sel  = unit_done[0];
      sel_res   = unit_res[WIDTH-1:0];
      sel_flags = unit_flags[2:0];
      case (sel_q)
         U_DIV: begin
            done_sel  = unit_done[1];
            sel_res   = unit_res[2*WIDTH-1:WIDTH];
            sel_flags = unit_flags[5:3];
         end
         U_MUL: begin
            done_sel  = unit_done[2];
            sel_res   = unit_res[3*WIDTH-1:2*WIDTH];
            sel_flags = unit_flags[8:6];
         end
         default: ;
      endcase
      unit_flags_n              = '0;
      unit_flags_n[FLG_UND]     = sel_flags[2];
      unit_flags_n[FLG_OVF]     = sel_flags[1];
      unit_flags_n[FLG_ZERO]    = sel_flags[0];
   end

   always_comb begin
      unit_start = '0;
      if ((state_q == S_ISSUE) && !op_nan_q) begin
         case (sel_q)
            U_DIV:   unit_start[1] = 1'b1;
            U_MUL:   unit_start[2] = 1'b1;
            default: unit_start[0] = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = S_ISSUE;
         S_ISSUE: state_d = op_nan_q ? S_HOLD : S_WAIT;
         S_WAIT:  if (done_sel || wd_expired) state_d = S_HOLD;
         S_HOLD:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // NaN screening is done at accept so ISSUE only needs a registered bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unit_a     <= '0;
         unit_b     <= '0;
         unit_sub   <= 1'b0;
         sel_q      <= U_ADD;
         op_nan_q   <= 1'b0;
         tag_q      <= '0;
         out_result <= '0;
         out_flags  <= '0;
         out_tag    <= '0;
      end else begin
         if (accept) begin
            unit_a   <= in_a;
            unit_b   <= in_b;
            unit_sub <= (funct_e'(in_funct) == FN_SUB);
            sel_q    <= unit_of(funct_e'(in_funct));
            op_nan_q <= is_nan(a_ext, EXP_W, MAN_W) | is_nan(b_ext, EXP_W, MAN_W);
            tag_q    <= in_tag;
         end
         if ((state_q == S_ISSUE) && op_nan_q) begin
            out_result             <= QNAN;
            out_flags              <= '0;
            out_flags[FLG_INVALID] <= 1'b1;
            out_tag                <= tag_q;
         end
         if (state_q == S_WAIT) begin
            if (done_sel) begin
               out_result <= sel_res;
               out_flags  <= unit_flags_n;
               out_tag    <= tag_q;
            end else if (wd_expired) begin
               out_result             <= QNAN;
               out_flags              <= '0;
               out_flags[FLG_TIMEOUT] <= 1'b1;
               out_tag                <= tag_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_fpu_dispatch_ctrl.sv
// Directed bench for fpu_dispatch_ctrl; the bench plays the arithmetic units and scoreboards results.
module tb_fpu_dispatch_ctrl;

   localparam logic [31:0] QNAN32 = 32'h7FC0_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_funct;
   logic [31:0] in_a, in_b;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_flags;
   logic [3:0]  out_tag;
   logic [2:0]  unit_start;
   logic        unit_sub;
   logic [31:0] unit_a, unit_b;
   logic [95:0] unit_res;
   logic [2:0]  unit_done;
   logic [8:0]  unit_flags;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  flg;
      logic [3:0]  tag;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   fpu_dispatch_ctrl #(
      .EXP_W  (8),
      .MAN_W  (23),
      .TAG_W  (4),
      .TIMEOUT(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_funct  (in_funct),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .out_flags (out_flags),
      .out_tag   (out_tag),
      .unit_start(unit_start),
      .unit_sub  (unit_sub),
      .unit_a    (unit_a),
      .unit_b    (unit_b),
      .unit_res  (unit_res),
      .unit_done (unit_done),
      .unit_flags(unit_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   // Presents one request and returns one cycle later, with the DUT in ISSUE.
   task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t);
      check("accept_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_funct = f;
      in_a     = a;
      in_b     = b;
      in_tag   = t;
      tick();
      in_valid = 1'b0;
      in_a     = 32'hFFFF_FFFF;
      in_b     = 32'hFFFF_FFFF;
      in_tag   = 4'h0;
   endtask

   task automatic unit_reply(input int idx, input logic [31:0] res, input logic [2:0] fl);
      unit_res[idx*32 +: 32]  = res;
      unit_flags[idx*3 +: 3]  = fl;
      unit_done[idx]          = 1'b1;
      tick();
      unit_done  = '0;
      unit_flags = '0;
   endtask

   task automatic drain(input string name);
      exp_t e;
      int unsigned n;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({name, "_valid"}, 64'(out_valid), 64'd1);
      check({name, "_sb_depth"}, 64'(sb.size()), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({name, "_result"}, 64'(out_result), 64'(e.res));
         check({name, "_flags"}, 64'(out_flags), 64'(e.flg));
         check({name, "_tag"}, 64'(out_tag), 64'(e.tag));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, "_released"}, 64'(out_valid), 64'd0);
      check({name, "_ready_again"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_funct   = 2'd0;
      in_a       = '0;
      in_b       = '0;
      in_tag     = '0;
      out_ready  = 1'b0;
      unit_res   = '0;
      unit_done  = '0;
      unit_flags = '0;
      tick();
      tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_unit_start", 64'(unit_start), 64'd0);
      check("rst_out_result", 64'(out_result), 64'd0);
      check("rst_out_flags", 64'(out_flags), 64'd0);
      check("rst_unit_a", 64'(unit_a), 64'd0);
      rst_n = 1'b1;
      tick();

      // add, unit answers in the second wait cycle
      send(2'd0, 32'h3F80_0000, 32'h4000_0000, 4'h5);
      sb.push_back('{32'h4040_0000, 5'b00000, 4'h5});
      check("add_start", 64'(unit_start), 64'b001);
      check("add_sub", 64'(unit_sub), 64'd0);
      check("add_unit_a", 64'(unit_a), 64'h3F80_0000);
      check("add_unit_b", 64'(unit_b), 64'h4000_0000);
      check("add_busy", 64'(in_ready), 64'd0);
      tick();
      check("add_start_pulse", 64'(unit_start), 64'b000);
      tick();
      unit_reply(0, 32'h4040_0000, 3'b000);
      drain("add");

      // sub, answers on first wait cycle: minimum latency
      send(2'd1, 32'h4000_0000, 32'h4000_0000, 4'h6);
      sb.push_back('{32'h0000_0000, 5'b00001, 4'h6});
      check("sub_start", 64'(unit_start), 64'b001);
      check("sub_sub", 64'(unit_sub), 64'd1);
      tick();
      unit_reply(0, 32'h0000_0000, 3'b001);
      check("sub_lat3", 64'(out_valid), 64'd1);
      drain("sub");

      // div, stray mul done must be ignored
      send(2'd2, 32'h3F80_0000, 32'h4000_0000, 4'h7);
      sb.push_back('{32'h3F00_0000, 5'b00010, 4'h7});
      check("div_start", 64'(unit_start), 64'b010);
      tick();
      unit_reply(2, 32'hDEAD_BEEF, 3'b111);
      check("div_stray_ignored", 64'(out_valid), 64'd0);
      unit_reply(1, 32'h3F00_0000, 3'b010);
      drain("div");

      // mul
      send(2'd3, 32'h4000_0000, 32'h4040_0000, 4'h8);
      sb.push_back('{32'h40C0_0000, 5'b00100, 4'h8});
      check("mul_start", 64'(unit_start), 64'b100);
      tick();
      unit_reply(2, 32'h40C0_0000, 3'b100);
      drain("mul");

      // NaN bypass on operand a
      send(2'd3, 32'h7FC0_0001, 32'h3F80_0000, 4'h9);
      sb.push_back('{QNAN32, 5'b10000, 4'h9});
      check("nan_a_no_start", 64'(unit_start), 64'b000);
      tick();
      check("nan_a_lat2", 64'(out_valid), 64'd1);
      check("nan_a_no_start_hold", 64'(unit_start), 64'b000);
      drain("nan_a");

      // signalling NaN on operand b
      send(2'd0, 32'h3F80_0000, 32'h7F80_0001, 4'hA);
      sb.push_back('{QNAN32, 5'b10000, 4'hA});
      check("nan_b_no_start", 64'(unit_start), 64'b000);
      drain("nan_b");

      // infinity is not NaN
      send(2'd0, 32'h7F80_0000, 32'h3F80_0000, 4'hA);
      sb.push_back('{32'h7F80_0000, 5'b00010, 4'hA});
      check("inf_start", 64'(unit_start), 64'b001);
      tick();
      unit_reply(0, 32'h7F80_0000, 3'b010);
      drain("inf");

      // timeout: 8 wait cycles with no done
      send(2'd2, 32'h3F80_0000, 32'h4000_0000, 4'hB);
      sb.push_back('{QNAN32, 5'b01000, 4'hB});
      check("to_start", 64'(unit_start), 64'b010);
      for (int i = 0; i < 8; i++) tick();
      check("to_still_waiting", 64'(out_valid), 64'd0);
      tick();
      check("to_fired", 64'(out_valid), 64'd1);
      drain("timeout");

      // done on the last permitted wait cycle wins over timeout
      send(2'd0, 32'h4000_0000, 32'h4000_0000, 4'hC);
      sb.push_back('{32'h4080_0000, 5'b00000, 4'hC});
      for (int i = 0; i < 8; i++) tick();
      check("to_edge_waiting", 64'(out_valid), 64'd0);
      unit_reply(0, 32'h4080_0000, 3'b000);
      check("to_edge_valid", 64'(out_valid), 64'd1);
      drain("to_edge");

      // backpressure: result held 10 cycles, new request not taken
      send(2'd3, 32'h3F80_0000, 32'h3F80_0000, 4'hD);
      sb.push_back('{32'h3F80_0000, 5'b00000, 4'hD});
      tick();
      unit_reply(2, 32'h3F80_0000, 3'b000);
      unit_res   = '1;
      in_valid   = 1'b1;
      in_funct   = 2'd1;
      in_tag     = 4'h3;
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_result", 64'(out_result), 64'h3F80_0000);
         check("bp_tag", 64'(out_tag), 64'hD);
         tick();
      end
      in_valid = 1'b0;
      drain("bp");

      // reset in WAIT aborts; a late done is ignored
      send(2'd2, 32'h4000_0000, 32'h3F80_0000, 4'hE);
      tick();
      tick();
      rst_n = 1'b0;
      #2;
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_start", 64'(unit_start), 64'd0);
      check("mid_rst_result", 64'(out_result), 64'd0);
      check("mid_rst_tag", 64'(out_tag), 64'd0);
      check("mid_rst_unit_a", 64'(unit_a), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      unit_reply(1, 32'h1234_5678, 3'b011);
      check("late_done_valid", 64'(out_valid), 64'd0);
      check("late_done_ready", 64'(in_ready), 64'd1);

      // recovery
      send(2'd0, 32'h3F80_0000, 32'h3F80_0000, 4'hF);
      sb.push_back('{32'h4000_0000, 5'b00000, 4'hF});
      check("rec_start", 64'(unit_start), 64'b001);
      tick();
      unit_reply(0, 32'h4000_0000, 3'b000);
      drain("recover");

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
